// File: rtl/nonce_result_collector.sv
// nonce_result_collector
//
// Multi-channel nonce result collector. Tracks broadcast rounds for the
// current block, captures per-channel success flags into one pending
// register per channel, builds the full nonce {round, channel, core index}
// and serialises results through a small FIFO towards the host reporter
// using a ready/valid handshake.
//
// Ports:
//   clk           clock (single domain)
//   rst           synchronous active-high reset
//   valid_i       broadcast cycle in progress; successes sampled only then
//   newblock_i    start of a new block; flushes all state
//   success_i     per-channel success flags
//   index_i       per-channel winning core index, channel c in slice c
//   out_valid_o   FIFO head valid
//   out_ready_i   consumer accepts the head
//   nonce_o       decoded nonce at the FIFO head
//   channel_o     source channel of the head
//   exhausted_o   sticky flag, round counter has wrapped
//   drop_count_o  saturating count of dropped successes
//
// Optional feature: define NONCE_COLLECTOR_DROP_CNT_EN to build the
// saturating drop counter; otherwise drop_count_o is tied to zero.

module nonce_result_collector #(
  parameter int NUM_CHANNELS  = 2,
  parameter int NUM_CORES     = 4,
  parameter int BROADCAST_CNT = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int NONCE_W       = 32,
  localparam int CH_W         = $clog2(NUM_CHANNELS),
  localparam int IDX_W        = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic                          newblock_i,
  input  logic [NUM_CHANNELS-1:0]       success_i,
  input  logic [NUM_CHANNELS*IDX_W-1:0] index_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NONCE_W-1:0]            nonce_o,
  output logic [CH_W-1:0]               channel_o,
  output logic                          exhausted_o,
  output logic [15:0]                   drop_count_o
);

  localparam int ROUND_W = NONCE_W - CH_W - IDX_W;
  localparam int PH_W    = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  logic [PH_W-1:0]         phase_q;
  logic [ROUND_W-1:0]      round_q;
  logic                    exhausted_q;
  logic [NUM_CHANNELS-1:0] pend_full_q;
  logic [NONCE_W-1:0]      pend_data_q [NUM_CHANNELS];
  logic [NONCE_W-1:0]      fifo_mem_q  [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q;
  logic [AW:0]             rd_ptr_q;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    wr_en;
  logic                    sel_valid;
  logic [CH_W-1:0]         sel;
  logic [NUM_CHANNELS-1:0] cap;
  logic [NUM_CHANNELS-1:0] clr;
  logic [NUM_CHANNELS-1:0] accept;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i && !newblock_i;

  // Head is forced to zero when empty so no stale entry is ever shown.
  assign nonce_o     = out_valid_o ? fifo_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign channel_o   = nonce_o[IDX_W +: CH_W];
  assign exhausted_o = exhausted_q;

  // Lowest-numbered full pending register wins the FIFO write slot.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (pend_full_q[c]) begin
        sel_valid = 1'b1;
        sel       = CH_W'(c);
      end
    end
  end

  // A full FIFO still accepts a write when the head pops in the same cycle.
  assign wr_en = sel_valid && (!fifo_full || pop) && !newblock_i;

  // A register emptied this cycle may take a new capture in the same cycle.
  always_comb begin
    clr = '0;
    if (wr_en) clr[sel] = 1'b1;
  end

  assign cap    = success_i & {NUM_CHANNELS{valid_i && !newblock_i}};
  assign accept = cap & (~pend_full_q | clr);

  // Broadcast phase/round tracking; a newblock cycle with valid counts as phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      round_q     <= '0;
      exhausted_q <= 1'b0;
    end else if (newblock_i) begin
      exhausted_q <= 1'b0;
      if (valid_i && (BROADCAST_CNT == 1)) begin
        phase_q <= '0;
        round_q <= ROUND_W'(1);
      end else if (valid_i) begin
        phase_q <= PH_W'(1);
        round_q <= '0;
      end else begin
        phase_q <= '0;
        round_q <= '0;
      end
    end else if (valid_i) begin
      if (phase_q == PH_W'(BROADCAST_CNT - 1)) begin
        phase_q <= '0;
        round_q <= round_q + ROUND_W'(1);
        if (&round_q) exhausted_q <= 1'b1;
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  // Pending occupancy: drained by the FIFO write, refilled by accepted captures.
  always_ff @(posedge clk) begin
    if (rst || newblock_i) begin
      pend_full_q <= '0;
    end else begin
      pend_full_q <= (pend_full_q & ~clr) | accept;
    end
  end

  // Pending payload uses the round value of the capture cycle itself.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept[c]) begin
        pend_data_q[c] <= {round_q, CH_W'(c), index_i[c*IDX_W +: IDX_W]};
      end
    end
  end

  // FIFO pointers; newblock flushes and overrides any pop or write.
  always_ff @(posedge clk) begin
    if (rst || newblock_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q[AW-1:0]] <= pend_data_q[sel];
  end

`ifdef NONCE_COLLECTOR_DROP_CNT_EN
  logic [NUM_CHANNELS-1:0] drop;
  logic [CH_W:0]           drop_num;
  logic [16:0]             drop_sum;
  logic [15:0]             drop_cnt_q;

  assign drop = cap & pend_full_q & ~clr;

  // Several channels can drop in the same cycle.
  always_comb begin
    drop_num = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      drop_num = drop_num + (CH_W+1)'(drop[c]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_num);

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || newblock_i) begin
      drop_cnt_q <= '0;
    end else if (drop_sum[16]) begin
      drop_cnt_q <= 16'hFFFF;
    end else begin
      drop_cnt_q <= drop_sum[15:0];
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_nonce_result_collector.sv
// Testbench for nonce_result_collector.
// Main instance uses default parameters; a second small instance
// (BROADCAST_CNT=1, NONCE_W=5) exercises round-counter exhaustion.

module tb_nonce_result_collector;

  localparam int BC        = 5;
  localparam int DEPTH     = 4;
  localparam int DROP_SAT  = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        newblock_i;
  logic [1:0]  success_i;
  logic [3:0]  index_i;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [31:0] nonce_o;
  logic [0:0]  channel_o;
  logic        exhausted_o;
  logic [15:0] drop_count_o;

  logic        s_valid;
  logic        s_newblock;
  logic [1:0]  s_success;
  logic [3:0]  s_index;
  logic        s_ready;
  logic        s_out_valid;
  logic [4:0]  s_nonce;
  logic [0:0]  s_channel;
  logic        s_exhausted;
  logic [15:0] s_drop;

  int          n_vec = 0;
  int          n_err = 0;
  int          pops  = 0;

  int          vcount;
  bit          pend_full [2];
  logic [31:0] pend_val  [2];
  int          mcnt;
  int          drops;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  nonce_result_collector u_dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .newblock_i   (newblock_i),
    .success_i    (success_i),
    .index_i      (index_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .nonce_o      (nonce_o),
    .channel_o    (channel_o),
    .exhausted_o  (exhausted_o),
    .drop_count_o (drop_count_o)
  );

  nonce_result_collector #(.BROADCAST_CNT(1), .NONCE_W(5)) u_small (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (s_valid),
    .newblock_i   (s_newblock),
    .success_i    (s_success),
    .index_i      (s_index),
    .out_valid_o  (s_out_valid),
    .out_ready_i  (s_ready),
    .nonce_o      (s_nonce),
    .channel_o    (s_channel),
    .exhausted_o  (s_exhausted),
    .drop_count_o (s_drop)
  );

  // Generic comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expDrops();
`ifdef NONCE_COLLECTOR_DROP_CNT_EN
    return (drops > DROP_SAT) ? 32'(DROP_SAT) : 32'(drops);
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the reference model, wait for the edge.
  // Model: round = valid cycles since block start / BC, one pending slot per
  // channel, FIFO as a queue of expected nonces.
  task automatic applyStimulus(input bit nb, input bit v, input logic [1:0] succ,
                               input logic [3:0] idx, input bit rdy);
    bit do_pop;
    int w;
    valid_i     = v;
    newblock_i  = nb;
    success_i   = succ;
    index_i     = idx;
    out_ready_i = rdy;
    if (nb) begin
      pend_full[0] = 0;
      pend_full[1] = 0;
      mcnt   = 0;
      drops  = 0;
      exp_q.delete();
      vcount = v ? 1 : 0;
    end else begin
      do_pop = (mcnt > 0) && rdy;
      w = -1;
      for (int c = 0; c < 2; c++) if (pend_full[c] && w < 0) w = c;
      if (w >= 0 && (mcnt < DEPTH || do_pop)) begin
        exp_q.push_back(pend_val[w]);
        pend_full[w] = 0;
        mcnt++;
      end
      if (do_pop) mcnt--;
      if (v) begin
        for (int c = 0; c < 2; c++) begin
          if (succ[c]) begin
            if (pend_full[c]) drops++;
            else begin
              pend_full[c] = 1;
              pend_val[c]  = {29'(vcount / BC), 1'(c), idx[2*c +: 2]};
            end
          end
        end
        vcount++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    valid_i = 0; newblock_i = 0; success_i = '0; index_i = '0; out_ready_i = 0;
    s_valid = 0; s_newblock = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pend_full[0] = 0;
    pend_full[1] = 0;
    mcnt = 0; drops = 0; vcount = 0;
    exp_q.delete();
  endtask

  task automatic smallStep(input bit nb, input bit v, input bit exp_exh, input string name);
    s_newblock = nb;
    s_valid    = v;
    @(posedge clk);
    #1;
    checkOutput(name, 32'(s_exhausted), 32'(exp_exh));
  endtask

  // Scoreboard monitor: whenever the DUT presents a head, it must match the
  // oldest expected entry; on a handshake that entry is retired.
  always @(negedge clk) begin
    if (!rst && !newblock_i && out_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL stale_output: got nonce %0d, expected no output", nonce_o);
      end else begin
        mon_e = exp_q[0];
        checkOutput("sb_nonce", nonce_o, mon_e);
        checkOutput("sb_channel", 32'(channel_o), 32'(mon_e[2]));
        if (out_ready_i) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0;
    s_success = '0;
    s_index   = '0;
    s_ready   = 1'b1;
    doReset();

    // Reset values and idle.
    checkOutput("rst_valid", 32'(out_valid_o), 0);
    checkOutput("rst_nonce", nonce_o, 0);
    checkOutput("rst_channel", 32'(channel_o), 0);
    checkOutput("rst_exhausted", 32'(exhausted_o), 0);
    checkOutput("rst_drop", 32'(drop_count_o), 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 2'b00, 4'h0, 0);
      checkOutput("idle_valid", 32'(out_valid_o), 0);
    end

    // newblock with valid counts as phase 0; success in round 1.
    applyStimulus(1, 1, 2'b00, 4'h0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 2'b00, 4'h0, 1);
    applyStimulus(0, 1, 2'b10, 4'b1000, 1);
    checkOutput("r1_t1_valid", 32'(out_valid_o), 0);
    applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("r1_t2_valid", 32'(out_valid_o), 1);
    checkOutput("r1_t2_nonce", nonce_o, 14);
    checkOutput("r1_t2_channel", 32'(channel_o), 1);
    applyStimulus(0, 0, 2'b00, 4'h0, 1);

    // Two simultaneous successes in round 0.
    applyStimulus(1, 0, 2'b00, 4'h0, 1);
    applyStimulus(0, 1, 2'b11, 4'b0111, 1);
    checkOutput("dual_t1_valid", 32'(out_valid_o), 0);
    applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("dual_t2_nonce", nonce_o, 3);
    checkOutput("dual_t2_channel", 32'(channel_o), 0);
    applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("dual_t3_nonce", nonce_o, 5);
    checkOutput("dual_t3_channel", 32'(channel_o), 1);
    applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("dual_t4_valid", 32'(out_valid_o), 0);

    // Back-pressure burst: 4 in FIFO, 1 pending, 2 drops.
    applyStimulus(1, 0, 2'b00, 4'h0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 2'b01, 4'($urandom), 0);
    applyStimulus(0, 0, 2'b00, 4'h0, 0);
    applyStimulus(0, 0, 2'b00, 4'h0, 0);
    checkOutput("burst_valid", 32'(out_valid_o), 1);
`ifdef NONCE_COLLECTOR_DROP_CNT_EN
    checkOutput("burst_drop", 32'(drop_count_o), 2);
`else
    checkOutput("burst_drop", 32'(drop_count_o), 0);
`endif
    p0 = pops;
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("burst_drain_count", 32'(pops - p0), 5);
    checkOutput("burst_drained_valid", 32'(out_valid_o), 0);

    // newblock flushes queued results.
    applyStimulus(1, 0, 2'b00, 4'h0, 0);
    applyStimulus(0, 1, 2'b11, 4'($urandom), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b00, 4'h0, 0);
    checkOutput("flush_pre_valid", 32'(out_valid_o), 1);
    applyStimulus(1, 0, 2'b00, 4'h0, 1);
    checkOutput("flush_valid", 32'(out_valid_o), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 2'b00, 4'h0, 1);
      checkOutput("flush_idle_valid", 32'(out_valid_o), 0);
    end

    // Randomized traffic with alternating light and heavy back-pressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom), 4'($urandom),
                    (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    checkOutput("rand_drop", 32'(drop_count_o), expDrops());
    checkOutput("rand_exhausted", 32'(exhausted_o), 0);
    for (int i = 0; i < 20 && (exp_q.size() > 0 || pend_full[0] || pend_full[1]); i++) begin
      applyStimulus(0, 0, 2'b00, 4'h0, 1);
    end
    applyStimulus(0, 0, 2'b00, 4'h0, 1);
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 0);
    checkOutput("drain_valid", 32'(out_valid_o), 0);

    // Round counter exhaustion on the small instance (ROUND_W = 2).
    smallStep(1, 0, 0, "exh_nb");
    smallStep(0, 1, 0, "exh_v1");
    smallStep(0, 1, 0, "exh_v2");
    smallStep(0, 1, 0, "exh_v3");
    smallStep(0, 1, 1, "exh_v4_wrap");
    smallStep(0, 0, 1, "exh_hold1");
    smallStep(0, 1, 1, "exh_hold2");
    smallStep(1, 0, 0, "exh_clear");
    smallStep(1, 1, 0, "exh_nbv");
    smallStep(0, 1, 0, "exh_nbv_v1");
    smallStep(0, 1, 0, "exh_nbv_v2");
    smallStep(0, 1, 1, "exh_nbv_wrap");
    smallStep(0, 0, 1, "exh_nbv_hold");
    s_valid = 0;
    checkOutput("small_valid", 32'(s_out_valid), 0);
    checkOutput("small_nonce", 32'(s_nonce), 0);
    checkOutput("small_channel", 32'(s_channel), 0);
    checkOutput("small_drop", 32'(s_drop), 0);

    // Mid-operation reset discards queued results.
    applyStimulus(1, 0, 2'b00, 4'h0, 0);
    applyStimulus(0, 1, 2'b11, 4'($urandom), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b00, 4'h0, 0);
    checkOutput("mid_rst_pre_valid", 32'(out_valid_o), 1);
    doReset();
    checkOutput("mid_rst_valid", 32'(out_valid_o), 0);
    checkOutput("mid_rst_small_exh", 32'(s_exhausted), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b00, 4'h0, 1);
      checkOutput("mid_rst_idle_valid", 32'(out_valid_o), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
